acc_flags_stage: RTL and testbench



---
 rtl/acc_flags_stage.sv | 112 +++++++++++
 tb/tb_acc_flags_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_flags_stage.sv
// Accumulator and Z/N/C/V flag stage driving an external ripple-carry adder.
// Accept an op, give the adder one full settle cycle, then hold the result until it is acknowledged.
module acc_flags_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_ADC  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;  // {Z, N, C, V}
  logic             accept;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;
  assign add_a     = acc_q;
  assign add_b     = b_q;
  assign add_cin   = cin_q;
  assign acc       = acc_q;
  assign flags     = flags_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_valid) state_d = S_SETTLE;
      S_SETTLE: state_d = S_HOLD;
      S_HOLD:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Operand conditioning: SUB becomes a + ~b + 1; ADC chains the current C flag.
  always_comb begin
    b_d   = in_operand;
    cin_d = 1'b0;
    unique case (op_t'(in_op))
      OP_ADC:  cin_d = flags_q[1];
      OP_SUB: begin
        b_d   = ~in_operand;
        cin_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    flags_d = flags_q;
    if (op_q == OP_LOAD) begin
      acc_d   = b_q;
      flags_d = {(b_q == '0), b_q[WIDTH-1], flags_q[1], 1'b0};
    end else begin
      acc_d   = add_sum;
      flags_d = {(add_sum == '0), add_sum[WIDTH-1], add_cout,
                 (acc_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != acc_q[WIDTH-1])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      b_q     <= '0;
      cin_q   <= 1'b0;
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_t'(in_op);
        b_q   <= b_d;
        cin_q <= cin_d;
      end
      if (state_q == S_SETTLE) begin
        acc_q   <= acc_d;
        flags_q <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_acc_flags_stage.sv
// Scoreboard bench for acc_flags_stage with a behavioural 16-bit adder in the loop.
module tb_acc_flags_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [15:0] in_operand = '0;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] acc;
  logic [3:0]  flags;
  logic [16:0] adder_full;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct packed {
    logic [15:0] acc;
    logic [3:0]  flags;
  } result_t;

  result_t exp_q[$];

  logic [15:0] m_acc = '0;
  logic        m_c   = 1'b0;

  always #5 clk = ~clk;

  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  assign add_sum    = adder_full[15:0];
  assign add_cout   = adder_full[16];

  acc_flags_stage #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc        (acc),
    .flags      (flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the stage in IDLE; returns at a falling edge in IDLE.
  task automatic do_op(input logic [1:0] op, input logic [15:0] opnd, input int unsigned hold);
    logic [15:0] exp_b, prev_acc, r;
    logic        exp_cin, c, v, found;
    logic [16:0] wide;
    int unsigned n;
    result_t     got, exp;

    prev_acc = m_acc;
    exp_b    = (op == 2'b11) ? ~opnd : opnd;
    exp_cin  = (op == 2'b11) ? 1'b1 : (op == 2'b10) ? m_c : 1'b0;
    c = m_c;
    v = 1'b0;
    case (op)
      2'b00: r = opnd;
      2'b11: begin
        r = m_acc - opnd;
        c = (m_acc >= opnd);
        v = (m_acc[15] != opnd[15]) && (r[15] != m_acc[15]);
      end
      default: begin
        wide = {1'b0, m_acc} + {1'b0, opnd} + {16'd0, (op == 2'b10) ? m_c : 1'b0};
        r = wide[15:0];
        c = wide[16];
        v = (m_acc[15] == opnd[15]) && (r[15] != m_acc[15]);
      end
    endcase
    m_acc = r;
    m_c   = c;
    exp_q.push_back({r, (r == 16'd0), r[15], c, v});

    check_eq("ready_idle", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    in_op      = op;
    in_operand = opnd;
    out_ready  = 1'b0;

    @(negedge clk);
    check_eq("ready_settle", 32'(in_ready), 32'd0);
    check_eq("ovalid_settle", 32'(out_valid), 32'd0);
    check_eq("add_a", 32'(add_a), 32'(prev_acc));
    check_eq("add_b", 32'(add_b), 32'(exp_b));
    check_eq("add_cin", 32'(add_cin), 32'(exp_cin));
    in_valid   = (hold > 0);
    in_op      = ~op;
    in_operand = opnd ^ 16'h5A5A;
    out_ready  = (hold == 0);

    found = 1'b0;
    n = 0;
    while (!found && n < 4) begin
      @(negedge clk);
      n++;
      if (out_valid) found = 1'b1;
    end
    check_eq("latency", n, 32'd1);
    exp = exp_q.pop_front();
    if (found) begin
      got = {acc, flags};
      check_eq("acc", 32'(got.acc), 32'(exp.acc));
      check_eq("flags", 32'(got.flags), 32'(exp.flags));
    end

    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("bp_ovalid", 32'(out_valid), 32'd1);
      check_eq("bp_ready", 32'(in_ready), 32'd0);
      check_eq("bp_acc", 32'(acc), 32'(exp.acc));
      check_eq("bp_flags", 32'(flags), 32'(exp.flags));
    end

    out_ready = 1'b1;
    @(negedge clk);
    check_eq("ovalid_done", 32'(out_valid), 32'd0);
    check_eq("ready_done", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    #1;
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_ovalid", 32'(out_valid), 32'd0);
    check_eq("rst_acc", 32'(acc), 32'd0);
    check_eq("rst_flags", 32'(flags), 32'd0);
    check_eq("rst_b", 32'(add_b), 32'd0);
    check_eq("rst_cin", 32'(add_cin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b00, 16'h1234, 0);
    do_op(2'b00, 16'h0005, 0);
    do_op(2'b11, 16'h0003, 0);
    do_op(2'b00, 16'h7FFF, 0);
    do_op(2'b01, 16'h0001, 0);
    do_op(2'b00, 16'hFFFF, 0);
    do_op(2'b01, 16'h0001, 0);
    do_op(2'b10, 16'h0000, 0);
    do_op(2'b11, 16'h0005, 5);
    do_op(2'b01, 16'h8000, 0);
    do_op(2'b01, 16'h8000, 2);
    do_op(2'b00, 16'h0000, 0);
    for (int k = 0; k < 6; k++)
      do_op(2'($urandom_range(3)), 16'($urandom), $urandom_range(2));

    do_op(2'b00, 16'h0020, 0);
    in_valid   = 1'b1;
    in_op      = 2'b01;
    in_operand = 16'h0010;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("abort_acc", 32'(acc), 32'd0);
    check_eq("abort_flags", 32'(flags), 32'd0);
    check_eq("abort_ovalid", 32'(out_valid), 32'd0);
    check_eq("abort_ready", 32'(in_ready), 32'd1);
    m_acc = '0;
    m_c   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("post_rst_ovalid", 32'(out_valid), 32'd0);
      check_eq("post_rst_acc", 32'(acc), 32'd0);
    end
    do_op(2'b01, 16'h0010, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
